// File: rtl/hazard_ctrl_unit_pkg.sv
// hazard_ctrl_unit_pkg: shared types and constants for the hazard/forwarding controller.
//   hz_trk_entry_t : one tracked in-flight producer {valid, rd, we, is_load}
//   hz_fwd_sel_t   : forwarding source, either regfile or a tracker entry index
//   HZ_REG_ZERO    : hardwired-zero register index, never matches
package hazard_ctrl_unit_pkg;
  localparam int HZ_RW = 5;
  localparam int HZ_IW = 4;
  localparam logic [HZ_RW-1:0] HZ_REG_ZERO = '0;
  typedef struct packed {
    logic             valid;
    logic [HZ_RW-1:0] rd;
    logic             we;
    logic             is_load;
  } hz_trk_entry_t;
  typedef struct packed {
    logic             regfile;
    logic [HZ_IW-1:0] idx;
  } hz_fwd_sel_t;
  function automatic logic hz_match(hz_trk_entry_t e, logic [HZ_RW-1:0] rs);
    return e.valid && e.we && e.rd == rs && rs != HZ_REG_ZERO;
  endfunction
endpackage

// File: rtl/hazard_ctrl_unit_track_pipe.sv
// hazard_ctrl_unit_track_pipe: NFWD-deep shadow pipe of producers past EX, frozen on back-pressure.
//   i_clk, i_rstn : clock, async active-low reset (clears every entry)
//   i_freeze      : hold all entries
//   i_entry       : EX-stage entry shifted into entry0
//   o_entries     : packed entries, entry k at [k*EW +: EW]
module hazard_ctrl_unit_track_pipe
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int NFWD = 3,
  localparam int EW = $bits(hz_trk_entry_t)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_freeze,
  input  logic [EW-1:0]     i_entry,
  output logic [NFWD*EW-1:0] o_entries
);
  hz_trk_entry_t [NFWD-1:0] ent_q, ent_d;
  always_comb begin
    ent_d = ent_q;
    if (!i_freeze) begin
      ent_d[0] = i_entry;
      for (int k = 1; k < NFWD; k++) ent_d[k] = ent_q[k-1];
    end
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) ent_q <= '0;
    else ent_q <= ent_d;
  assign o_entries = ent_q;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline hazard/forwarding controller (load-use interlock, flush, mem stall, watchdog, perf count).
//   i_clk/i_rstn            : clock, async active-low reset
//   i_id_rs1/rs2            : ID source regs (interlock check)
//   i_ex_*                  : EX instruction descriptor and regfile operands
//   i_stage_data            : per tracker entry result, entry k at [k*XLEN +: XLEN]
//   i_redirect, i_mem_busy  : branch taken in EX, memory back-pressure
//   o_stall_*/o_bubble_ex/o_flush_* : pipeline control
//   o_ex_rs1/rs2_data       : forwarded operands
//   o_wdog_err, o_stall_cnt : sticky mem-stall watchdog, saturating stall counter
// Register indices are carried internally at 5 bits, so NREGS is limited to 32.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int NREGS       = 32,
  parameter int XLEN        = 32,
  parameter int NFWD        = 3,
  parameter int LOAD_LAT    = 1,
  parameter int WDOG_CYCLES = 1024,
  parameter int CNT_W       = 32,
  localparam int RW = $clog2(NREGS)
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [RW-1:0]        i_id_rs1,
  input  logic [RW-1:0]        i_id_rs2,
  input  logic                 i_ex_valid,
  input  logic [RW-1:0]        i_ex_rd,
  input  logic                 i_ex_we,
  input  logic                 i_ex_is_load,
  input  logic [RW-1:0]        i_ex_rs1,
  input  logic [RW-1:0]        i_ex_rs2,
  input  logic [XLEN-1:0]      i_ex_rs1_data,
  input  logic [XLEN-1:0]      i_ex_rs2_data,
  input  logic [NFWD*XLEN-1:0] i_stage_data,
  input  logic                 i_redirect,
  input  logic                 i_mem_busy,
  output logic                 o_stall_if,
  output logic                 o_stall_id,
  output logic                 o_stall_ex,
  output logic                 o_stall_mem,
  output logic                 o_bubble_ex,
  output logic                 o_flush_if_id,
  output logic                 o_flush_id_ex,
  output logic [XLEN-1:0]      o_ex_rs1_data,
  output logic [XLEN-1:0]      o_ex_rs2_data,
  output logic                 o_wdog_err,
  output logic [CNT_W-1:0]     o_stall_cnt
);
  localparam int EW = $bits(hz_trk_entry_t);
  localparam int WW = $clog2(WDOG_CYCLES + 2);
  localparam logic [WW-1:0] WD_MAX = WW'(WDOG_CYCLES);
  logic [NFWD*EW-1:0] trk_flat;
  hz_trk_entry_t [NFWD-1:0] trk;
  hz_trk_entry_t ex_ent;
  logic [HZ_RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2;
  hz_fwd_sel_t sel1, sel2;
  logic [XLEN-1:0] fwd1, fwd2;
  logic ld1, ld2, bad1, bad2, ld_use;
  logic [WW-1:0] wd_q, wd_d;
  logic err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign id_rs1 = HZ_RW'(i_id_rs1);
  assign id_rs2 = HZ_RW'(i_id_rs2);
  assign ex_rs1 = HZ_RW'(i_ex_rs1);
  assign ex_rs2 = HZ_RW'(i_ex_rs2);
  // x0 destinations are stored with we=0 so they can never forward or interlock.
  assign ex_ent = '{valid: i_ex_valid, rd: HZ_RW'(i_ex_rd), we: i_ex_we && i_ex_rd != '0, is_load: i_ex_is_load};
  hazard_ctrl_unit_track_pipe #(.NFWD(NFWD)) u_trk (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_freeze (i_mem_busy),
    .i_entry  (ex_ent),
    .o_entries(trk_flat)
  );
  assign trk = trk_flat;
  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel1 = '{regfile: 1'b1, idx: '0};
    sel2 = '{regfile: 1'b1, idx: '0};
    fwd1 = '0;
    fwd2 = '0;
    ld1  = 1'b0;
    ld2  = 1'b0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (hz_match(trk[k], ex_rs1)) begin
        sel1 = '{regfile: 1'b0, idx: HZ_IW'(k)};
        fwd1 = i_stage_data[k*XLEN +: XLEN];
        ld1  = trk[k].is_load;
      end
      if (hz_match(trk[k], ex_rs2)) begin
        sel2 = '{regfile: 1'b0, idx: HZ_IW'(k)};
        fwd2 = i_stage_data[k*XLEN +: XLEN];
        ld2  = trk[k].is_load;
      end
    end
  end
  assign o_ex_rs1_data = sel1.regfile ? i_ex_rs1_data : fwd1;
  assign o_ex_rs2_data = sel2.regfile ? i_ex_rs2_data : fwd2;
  // A load younger than LOAD_LAT has no data yet; the interlock must have kept its consumer out of EX.
  assign bad1 = !sel1.regfile && ld1 && sel1.idx < HZ_IW'(LOAD_LAT);
  assign bad2 = !sel2.regfile && ld2 && sel2.idx < HZ_IW'(LOAD_LAT);
  a_no_early_load_fwd : assert property (@(posedge i_clk) disable iff (!i_rstn) !(i_ex_valid && (bad1 || bad2)));
  always_comb begin
    ld_use = LOAD_LAT > 0 && ex_ent.is_load && (hz_match(ex_ent, id_rs1) || hz_match(ex_ent, id_rs2));
    for (int k = 0; k < NFWD; k++)
      if (k + 1 < LOAD_LAT && trk[k].is_load && (hz_match(trk[k], id_rs1) || hz_match(trk[k], id_rs2)))
        ld_use = 1'b1;
  end
  // Busy freezes everything, including a pending redirect, which then flushes on the release cycle.
  assign o_stall_ex    = i_mem_busy;
  assign o_stall_mem   = i_mem_busy;
  assign o_flush_if_id = !i_mem_busy && i_redirect;
  assign o_flush_id_ex = !i_mem_busy && i_redirect;
  assign o_stall_if    = i_mem_busy || (!i_redirect && ld_use);
  assign o_stall_id    = o_stall_if;
  assign o_bubble_ex   = !i_mem_busy && !i_redirect && ld_use;
  always_comb begin
    wd_d  = !i_mem_busy ? '0 : (wd_q == WD_MAX ? wd_q : wd_q + 1'b1);
    err_d = err_q || (WDOG_CYCLES != 0 && i_mem_busy && wd_q == WD_MAX - 1'b1);
    cnt_d = (o_stall_if && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      wd_q  <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  assign o_wdog_err  = err_q;
  assign o_stall_cnt = cnt_q;
endmodule
